instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end for the MiniRISC core; the producer side of the opcode interface that the main control decoder consumes.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Holds the fetched instruction in a one-entry buffer and presents instr/opcode to decode.
- Accepts branch redirects from execute and discards any in-flight fetch on redirect.

Parameters:
- ADDR_W, 32, PC and imem address width
- INSTR_W, 32, instruction width; opcode = instr[INSTR_W-1 -: 4]
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, byte increment between sequential instructions

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  instruction word
- stall  in  1  decode not accepting; instr held
- redirect  in  1  branch taken / PC load, single-cycle pulse
- redirect_pc  in  ADDR_W  new PC, sampled when redirect=1
- branch_resolved  in  1  branch not taken, pulse; used only with the optional feature
- instr_valid  out  1  instr/opcode/pc_out valid
- instr  out  INSTR_W  buffered instruction
- opcode  out  4  instr opcode; forced to 4'b0000 when instr_valid=0
- pc_out  out  ADDR_W  address of instr
- pc_plus  out  ADDR_W  pc_out+PC_STEP; link value for bl

Behaviour:
- Reset (async, rst_n=0):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, pc_out=RESET_PC, pc_plus=RESET_PC+PC_STEP.
  - State = S_FETCH.
  - imem_req rises on the first clk edge after rst_n deasserts.
- States: S_FETCH, S_HOLD, S_DISCARD; S_WAITBR exists only with the optional feature.
- S_FETCH:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_ack: instr<=imem_rdata, pc_out<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP, instr_valid<=1, go to S_HOLD.
  - Latency: ack at edge N gives instr_valid=1 after edge N.
- S_HOLD:
  - imem_req=0; outputs stable.
  - If stall=0 the instruction is consumed this cycle: instr_valid<=0, go to S_FETCH.
  - If stall=1, remain in S_HOLD.
  - Sustained throughput: one instruction per 3 cycles with zero-wait memory.
- Redirect: highest priority in every state.
  - fetch_pc<=redirect_pc, instr_valid<=0.
  - If imem_req=1 and imem_ack=0 this cycle, go to S_DISCARD. Otherwise go to S_FETCH; a same-cycle ack's data is dropped.
- S_DISCARD:
  - imem_req=1 with the old address unchanged, to honour the handshake.
  - On ack: drop the data, go to S_FETCH using the redirected fetch_pc.
  - A further redirect while in S_DISCARD overwrites fetch_pc; state stays S_DISCARD.
- Arithmetic and output rules:
  - fetch_pc+PC_STEP wraps modulo 2^ADDR_W with no flag.
  - opcode is combinational from instr, gated by instr_valid, so decode sees the default (all-zero control) when there is no valid instruction.
- Ignored inputs:
  - stall is ignored when instr_valid=0.
  - imem_ack is ignored when imem_req=0.
- An asynchronous reset mid-handshake abandons the request. The memory must tolerate a dropped req.

Optional Feature:
- Macro: IFU_BRANCH_HOLD_EN.
- Defined:
  - When an instruction with opcode 6..13 (b, br, bltz, bz, bnz, bl, bcy, 13) is consumed, go to S_WAITBR instead of S_FETCH.
  - In S_WAITBR: imem_req=0.
  - redirect: load redirect_pc, go to S_FETCH.
  - branch_resolved: go to S_FETCH with the sequential fetch_pc.
  - Both in the same cycle: redirect wins.
- Undefined:
  - S_WAITBR and its logic are absent and branch_resolved is ignored.
  - Sequential fetch continues past branches; wrong-path work is flushed by redirect.

Decomposition:
- Shared package minirisc_pkg holds:
  - opcode constants OP_ALU=1, OP_ADDI=2, OP_COMPI=3, OP_LW=4, OP_SW=5, OP_B=6 … OP_DIFF=14, OP_NOP=0
  - function is_branch_op(opcode)
  - IFU state encoding
  - RESET_PC default
- The main control decoder reuses the same opcode constants.
- No sub-module: the FSM, PC and buffer stay in one module.

Test Plan:
- Reset release, zero-wait ack, stall=0 → fetch addresses 0x0, 0x4, 0x8 are requested. opcode matches imem_rdata[31:28]; instr_valid pulses every 3rd cycle.
- Ack delayed 3 cycles with stall=1 for 4 cycles after capture → imem_addr is held while req=1. instr and pc_out are unchanged during the stall, and no new req occurs until stall=0.
- Redirect to 0x100 while req is outstanding at 0x8, ack 2 cycles later → ack data is dropped and the next req is at 0x100. instr_valid stays 0 until the 0x100 data arrives.
- Redirect in the same cycle as ack → data is dropped and the next req is at redirect_pc. opcode reads 0 in between.
- fetch_pc=0xFFFFFFFC, ack → next req is at 0x0 and pc_plus=0x0.
- IFU_BRANCH_HOLD_EN defined, bz (opcode 9) consumed → imem_req=0 until branch_resolved, then the req resumes at pc+4. A repeat with redirect to 0x40 resumes at 0x40.

Source files
------------

// File: rtl/minirisc_pkg.sv
// minirisc_pkg: opcode constants, branch classifier and fetch-unit
// state encoding shared by the fetch front end and the control decoder.
package minirisc_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_COMPI = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_B     = 4'd6;
    localparam logic [3:0] OP_BR    = 4'd7;
    localparam logic [3:0] OP_BLTZ  = 4'd8;
    localparam logic [3:0] OP_BZ    = 4'd9;
    localparam logic [3:0] OP_BNZ   = 4'd10;
    localparam logic [3:0] OP_BL    = 4'd11;
    localparam logic [3:0] OP_BCY   = 4'd12;
    localparam logic [3:0] OP_B13   = 4'd13;
    localparam logic [3:0] OP_DIFF  = 4'd14;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2,
        S_WAITBR  = 2'd3
    } ifu_state_e;

    // Opcodes 6..13 form the branch group.
    function automatic logic is_branch_op(input logic [3:0] op);
        return (op >= OP_B) && (op <= OP_B13);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MiniRISC fetch front end. Owns the PC, fetches one
// word at a time over imem req/ack, buffers it for decode, and handles
// branch redirects by discarding in-flight fetches.
// Ports: clk, rst_n (async low); imem_req/imem_addr/imem_ack/imem_rdata;
// stall, redirect/redirect_pc, branch_resolved from the pipeline;
// instr_valid/instr/opcode/pc_out/pc_plus to decode.
// Optional macro IFU_BRANCH_HOLD_EN: after a branch is consumed, wait
// for resolution (redirect or branch_resolved) before fetching again.
module instr_fetch_unit
    import minirisc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               branch_resolved,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

    ifu_state_e         r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_req;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_out;

    logic [3:0]         w_opcode;
    ifu_state_e         w_hold_next;

    assign w_opcode = r_instr[INSTR_W-1 -: 4];

`ifdef IFU_BRANCH_HOLD_EN
    assign w_hold_next = is_branch_op(w_opcode) ? S_WAITBR : S_FETCH;
`else
    logic w_unused;
    assign w_unused    = branch_resolved;
    assign w_hold_next = S_FETCH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RST_PC;
            r_addr     <= RST_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc_out   <= RST_PC;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_valid    <= 1'b0;
            // An open handshake must still complete before refetching.
            if (r_req && !imem_ack) begin
                r_state <= S_DISCARD;
            end else begin
                r_state <= S_FETCH;
                r_req   <= 1'b0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Request is raised one cycle after entering FETCH.
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= r_fetch_pc;
                    end else if (imem_ack) begin
                        r_req      <= 1'b0;
                        r_instr    <= imem_rdata;
                        r_pc_out   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + STEP;
                        r_valid    <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        r_state <= w_hold_next;
                    end
                end
                S_DISCARD: begin
                    // Old address stays on the bus; data is dropped.
                    if (imem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
`ifdef IFU_BRANCH_HOLD_EN
                S_WAITBR: begin
                    if (branch_resolved) begin
                        r_state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign opcode      = r_valid ? w_opcode : OP_NOP;
    assign pc_out      = r_pc_out;
    assign pc_plus     = r_pc_out + STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus a randomized stream
// checked against an address/instruction-stream reference model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        branch_resolved;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;

    int checks;
    int errors;

    bit          p_req;
    bit          p_ack;
    bit          in_req;
    bit          lat_rand;
    bit          ovr_en;
    int unsigned lat_cfg;
    int unsigned wait_cnt;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .branch_resolved (branch_resolved),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .opcode          (opcode),
        .pc_out          (pc_out),
        .pc_plus         (pc_plus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
`ifdef IFU_BRANCH_HOLD_EN
        if (w[31:28] >= 4'd6 && w[31:28] <= 4'd13)
            w[31:28] = w[31:28] + 4'd8;
`endif
        if (ovr_en && (a == 32'h80 || a == 32'hC0))
            w[31:28] = 4'd9;
        return w;
    endfunction

    // One clock; afterwards the memory model answers the current req.
    task automatic cycle();
        p_req = imem_req;
        p_ack = imem_ack;
        @(posedge clk);
        #1;
        redirect        = 1'b0;
        branch_resolved = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = $urandom;
        if (!imem_req) begin
            in_req = 1'b0;
        end else begin
            if (!in_req) begin
                in_req   = 1'b1;
                wait_cnt = lat_rand ? $urandom_range(lat_cfg, 0) : lat_cfg;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                in_req     = 1'b0;
            end else begin
                wait_cnt = wait_cnt - 1;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        branch_resolved = 1'b0;
        imem_ack        = 1'b0;
        in_req          = 1'b0;
        lat_rand        = 1'b0;
        lat_cfg         = 0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            ok = imem_req && !p_req;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            ok = instr_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lat_cfg = 0;
        lat_rand = 1'b0;
        repeat (2) cycle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0 || opcode !== 4'h0) begin errors++; $display("FAIL rst_instr got %h/%h want 0/0", instr, opcode); end
        checks++; if (pc_out !== 32'h0 || pc_plus !== 32'h4) begin errors++; $display("FAIL rst_pc got %h/%h want 0/4", pc_out, pc_plus); end
        lat_cfg = 5;
        rst_n = 1'b1;
        cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req got %b@%h want 1@0", imem_req, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_async got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req, exp_pc, w;
        int last, nv;
        apply_reset();
        exp_req = 0; exp_pc = 0; last = -1; nv = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (imem_req && !p_req) begin
                checks++; if (imem_addr !== exp_req) begin errors++; $display("FAIL seq_req got %h want %h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (instr_valid) begin
                w = mem_word(exp_pc);
                checks++; if (pc_out !== exp_pc || instr !== w) begin errors++; $display("FAIL seq_data got %h:%h want %h:%h", pc_out, instr, exp_pc, w); end
                checks++; if (opcode !== w[31:28]) begin errors++; $display("FAIL seq_opcode got %h want %h", opcode, w[31:28]); end
                if (last >= 0) begin
                    checks++; if (c - last != 3) begin errors++; $display("FAIL seq_rate got %0d want 3", c - last); end
                end
                last = c; exp_pc += 32'd4; nv++;
            end else begin
                checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL seq_opc_gate got %h want 0", opcode); end
            end
        end
        checks++; if (nv != 7) begin errors++; $display("FAIL seq_count got %0d want 7", nv); end
    endtask

    task automatic test_stall_hold();
        bit ok;
        logic [31:0] w;
        apply_reset();
        lat_cfg = 3;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sh_req_timeout got none want req"); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL sh_addr_hold got %b@%h v%b want 1@0 v0", imem_req, imem_addr, instr_valid); end
        end
        stall = 1'b1;
        cycle();
        w = mem_word(32'h0);
        checks++; if (instr_valid !== 1'b1 || instr !== w || pc_out !== 32'h0) begin errors++; $display("FAIL sh_capture got %b %h@%h want 1 %h@0", instr_valid, instr, pc_out, w); end
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++; if (instr_valid !== 1'b1 || instr !== w || pc_out !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL sh_stall got v%b %h@%h r%b want v1 %h@0 r0", instr_valid, instr, pc_out, imem_req, w); end
        end
        stall = 1'b0;
        lat_cfg = 0;
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h4) begin errors++; $display("FAIL sh_next_req got %b@%h want 1@4", ok, imem_addr); end
    endtask

    task automatic test_redirect_outstanding();
        bit ok;
        logic [31:0] w;
        apply_reset();
        wait_req(ok);
        wait_req(ok);
        lat_cfg = 2;
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h8) begin errors++; $display("FAIL ro_req8 got %b@%h want 1@8", ok, imem_addr); end
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("FAIL ro_discard got %b@%h v%b want 1@8 v0", imem_req, imem_addr, instr_valid); end
        cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL ro_discard2 got %b@%h want 1@8", imem_req, imem_addr); end
        cycle();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || opcode !== 4'h0) begin errors++; $display("FAIL ro_drop got r%b v%b op%h want r0 v0 op0", imem_req, instr_valid, opcode); end
        lat_cfg = 0;
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h100) begin errors++; $display("FAIL ro_newreq got %b@%h want 1@100", ok, imem_addr); end
        wait_valid(ok);
        w = mem_word(32'h100);
        checks++; if (!ok || pc_out !== 32'h100 || instr !== w) begin errors++; $display("FAIL ro_data got %h:%h want 100:%h", pc_out, instr, w); end
    endtask

    task automatic test_redirect_with_ack();
        bit ok;
        logic [31:0] w;
        apply_reset();
        wait_req(ok);
        checks++; if (!ok || imem_ack !== 1'b1) begin errors++; $display("FAIL ra_ack got %b/%b want 1/1", ok, imem_ack); end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        checks++; if (instr_valid !== 1'b0 || opcode !== 4'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL ra_drop got v%b op%h r%b want v0 op0 r0", instr_valid, opcode, imem_req); end
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h200) begin errors++; $display("FAIL ra_newreq got %b@%h want 1@200", ok, imem_addr); end
        wait_valid(ok);
        w = mem_word(32'h200);
        checks++; if (!ok || pc_out !== 32'h200 || instr !== w) begin errors++; $display("FAIL ra_data got %h:%h want 200:%h", pc_out, instr, w); end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        wait_valid(ok);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_req got %b@%h want 1@fffffffc", ok, imem_addr); end
        wait_valid(ok);
        checks++; if (!ok || pc_out !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin errors++; $display("FAIL wr_pc got %h/%h want fffffffc/0", pc_out, pc_plus); end
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next got %b@%h want 1@0", ok, imem_addr); end
    endtask

    task automatic test_branch();
        bit ok;
        apply_reset();
        ovr_en = 1'b1;
        wait_valid(ok);
        redirect = 1'b1;
        redirect_pc = 32'h80;
        wait_valid(ok);
        checks++; if (!ok || pc_out !== 32'h80 || opcode !== 4'd9) begin errors++; $display("FAIL br_bz got %h op%h want 80 op9", pc_out, opcode); end
`ifdef IFU_BRANCH_HOLD_EN
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_wait got %b want 0", imem_req); end
        end
        branch_resolved = 1'b1;
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h84) begin errors++; $display("FAIL br_resume got %b@%h want 1@84", ok, imem_addr); end
        wait_valid(ok);
        redirect = 1'b1;
        redirect_pc = 32'hC0;
        wait_valid(ok);
        checks++; if (!ok || pc_out !== 32'hC0 || opcode !== 4'd9) begin errors++; $display("FAIL br_bz2 got %h op%h want c0 op9", pc_out, opcode); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_wait2 got %b want 0", imem_req); end
        end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        branch_resolved = 1'b1;
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h40) begin errors++; $display("FAIL br_redir got %b@%h want 1@40", ok, imem_addr); end
`else
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h84) begin errors++; $display("FAIL br_seq got %b@%h want 1@84", ok, imem_addr); end
`endif
        ovr_en = 1'b0;
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_next, cur_req, cur_pc, cur_w, w;
        bit pv, ps, pr;
        int got;
        apply_reset();
        lat_rand = 1'b1;
        lat_cfg = 3;
        exp_next = 0; cur_req = 0; cur_pc = 0; cur_w = 0;
        got = 0; pv = 0; ps = 0; pr = 0;
        for (int c = 0; c < 4000 && got < 80; c++) begin
            cycle();
            if (instr_valid && !pv) begin
                w = mem_word(exp_next);
                checks++; if (!p_ack || pr) begin errors++; $display("FAIL rnd_src got ack%b redir%b want ack1 redir0", p_ack, pr); end
                checks++; if (pc_out !== exp_next || instr !== w || pc_plus !== exp_next + 32'd4) begin errors++; $display("FAIL rnd_data got %h:%h want %h:%h", pc_out, instr, exp_next, w); end
                cur_w = w; cur_pc = exp_next;
                exp_next += 32'd4; got++;
            end
            if (pv && ps && !pr) begin
                checks++; if (instr_valid !== 1'b1 || instr !== cur_w || pc_out !== cur_pc || imem_req !== 1'b0) begin errors++; $display("FAIL rnd_stall got v%b %h@%h r%b want v1 %h@%h r0", instr_valid, instr, pc_out, imem_req, cur_w, cur_pc); end
            end
            if (p_ack) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_drop got %b want 0", imem_req); end
            end else if (imem_req && p_req) begin
                checks++; if (imem_addr !== cur_req) begin errors++; $display("FAIL rnd_addr_hold got %h want %h", imem_addr, cur_req); end
            end
            if (imem_req && !p_req) begin
                checks++; if (imem_addr !== exp_next) begin errors++; $display("FAIL rnd_req_addr got %h want %h", imem_addr, exp_next); end
                cur_req = exp_next;
            end
            w = instr_valid ? cur_w : 32'h0;
            checks++; if (opcode !== w[31:28]) begin errors++; $display("FAIL rnd_opcode got %h want %h", opcode, w[31:28]); end
            pr = ($urandom_range(99, 0) < 8);
            if (pr) begin
                redirect = 1'b1;
                redirect_pc = $urandom & 32'hFFFF_FFFC;
                exp_next = redirect_pc;
            end
            ps = ($urandom_range(99, 0) < 35);
            stall = ps;
            branch_resolved = ($urandom_range(99, 0) < 5);
            pv = instr_valid;
        end
        checks++; if (got < 80) begin errors++; $display("FAIL rnd_timeout got %0d want 80", got); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        branch_resolved = 1'b0;
        p_req = 1'b0;
        p_ack = 1'b0;
        in_req = 1'b0;
        lat_rand = 1'b0;
        ovr_en = 1'b0;
        lat_cfg = 0;
        wait_cnt = 0;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_outstanding();
        test_redirect_with_ack();
        test_wrap();
        test_branch();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
